// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: ALU op codes, opcode constants, decoded bundle.
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001,
        ALU_NONE = 4'b1010,
        ALU_EQ   = 4'b1011,
        ALU_GE   = 4'b1100,
        ALU_GEU  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } a_sel_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        alu_op_t     alu_op;
        a_sel_t      a_sel;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic        br_invert;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic        illegal;
    } dec_bundle_t;

    // funct3 -> register/immediate ALU op, before the funct7[5] SUB/SRA variant
    function automatic alu_op_t f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational RV32I instruction decode into the ALU-facing bundle.
module instr_decode_comb
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output dec_bundle_t dec_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    logic        wr;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec_o         = '0;
        dec_o.alu_op  = ALU_NONE;
        dec_o.a_sel   = A_RS1;
        dec_o.rs1     = instr_i[19:15];
        dec_o.rs2     = instr_i[24:20];
        dec_o.rd      = instr_i[11:7];
        dec_o.funct3  = f3;
        dec_o.pc      = pc_i;
        legal         = 1'b1;
        wr            = 1'b0;
        case (opc)
            OPC_OP: begin
                wr           = 1'b1;
                dec_o.alu_op = f3_op(f3);
                if (f7 == 7'b0100000 && f3 == 3'b000) dec_o.alu_op = ALU_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101) dec_o.alu_op = ALU_SRA;
                else if (f7 != 7'b0000000) legal = 1'b0;
            end
            OPC_OP_IMM: begin
                wr            = 1'b1;
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_i;
                dec_o.alu_op  = f3_op(f3);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec_o.imm = {27'b0, instr_i[24:20]};
                    if (f7 == 7'b0100000 && f3 == 3'b101) dec_o.alu_op = ALU_SRA;
                    else if (f7 != 7'b0000000) legal = 1'b0;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                wr            = 1'b1;
                dec_o.a_sel   = (opc == OPC_LUI) ? A_ZERO : A_PC;
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_u;
                dec_o.alu_op  = ALU_ADD;
            end
            OPC_JAL: begin
                wr            = 1'b1;
                dec_o.a_sel   = A_PC;
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_j;
                dec_o.alu_op  = ALU_ADD;
                dec_o.is_jump = 1'b1;
            end
            OPC_JALR: begin
                wr            = 1'b1;
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_i;
                dec_o.alu_op  = ALU_ADD;
                dec_o.is_jump = 1'b1;
            end
            OPC_LOAD: begin
                wr            = 1'b1;
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_i;
                dec_o.alu_op  = ALU_ADD;
                dec_o.is_load = 1'b1;
            end
            OPC_STORE: begin
                dec_o.use_imm  = 1'b1;
                dec_o.imm      = imm_s;
                dec_o.alu_op   = ALU_ADD;
                dec_o.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                dec_o.imm       = imm_b;
                dec_o.is_branch = 1'b1;
                dec_o.br_invert = f3[0];
                case (f3[2:1])
                    2'b00:   dec_o.alu_op = ALU_EQ;
                    2'b10:   dec_o.alu_op = ALU_SLT;
                    2'b11:   dec_o.alu_op = ALU_SLTU;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings still flow down the pipe, but inert
        if (!legal) begin
            dec_o.alu_op    = ALU_NONE;
            dec_o.a_sel     = A_RS1;
            dec_o.use_imm   = 1'b0;
            dec_o.imm       = '0;
            dec_o.is_branch = 1'b0;
            dec_o.br_invert = 1'b0;
            dec_o.is_jump   = 1'b0;
            dec_o.is_load   = 1'b0;
            dec_o.is_store  = 1'b0;
            dec_o.illegal   = 1'b1;
        end
        dec_o.rd_we = wr & legal & (instr_i[11:7] != 5'd0);
    end

endmodule

// File: rtl/alu_decoder.sv
// Decode stage: registered decoded bundle with a one-entry skid buffer.
module alu_decoder
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic [1:0]  out_a_sel,
    output logic        out_use_imm,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_is_branch,
    output logic        out_br_invert,
    output logic        out_is_jump,
    output logic        out_is_load,
    output logic        out_is_store,
    output logic [2:0]  out_funct3,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    dec_bundle_t dec;
    dec_bundle_t out_q, out_d, skid_q, skid_d, rst_b;
    logic        out_vld_q, out_vld_d;
    logic        skid_vld_q, skid_vld_d;
    logic        in_rdy_q;
    logic        accept, drain;

    instr_decode_comb u_dec (
        .instr_i (instr),
        .pc_i    (pc),
        .dec_o   (dec)
    );

    assign accept = in_valid & in_rdy_q;
    assign drain  = out_vld_q & out_ready;

    always_comb begin
        rst_b        = '0;
        rst_b.alu_op = ALU_NONE;
        rst_b.pc     = RESET_PC;
    end

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // in_ready is low here, so only the skid can refill the output
            if (drain) begin
                out_d      = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (!out_vld_q || out_ready) begin
            out_vld_d = accept;
            if (accept) out_d = dec;
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= rst_b;
            skid_q     <= rst_b;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= ~skid_vld_d;
        end
    end

    assign in_ready      = in_rdy_q;
    assign out_valid     = out_vld_q;
    assign out_alu_op    = out_q.alu_op;
    assign out_a_sel     = out_q.a_sel;
    assign out_use_imm   = out_q.use_imm;
    assign out_imm       = out_q.imm;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_rd        = out_q.rd;
    assign out_rd_we     = out_q.rd_we;
    assign out_is_branch = out_q.is_branch;
    assign out_br_invert = out_q.br_invert;
    assign out_is_jump   = out_q.is_jump;
    assign out_is_load   = out_q.is_load;
    assign out_is_store  = out_q.is_store;
    assign out_funct3    = out_q.funct3;
    assign out_pc        = out_q.pc;
    assign out_illegal   = out_q.illegal;

endmodule

// File: doc/alu_decoder.md
Name: alu_decoder

Overview:
- Decode-stage block that drives the ALU's operand and op interface from a raw RV32I instruction word.
- Sits between instruction fetch and execute, in front of `alu`.
- Decodes opcode/funct3/funct7 into `alu_op`, immediate, operand selects, register indices and control flags.
- Registers the decoded bundle behind a valid/ready handshake, with a one-entry skid buffer so `in_ready` is a registered signal.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on `out_pc` while `out_valid` = 0 after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  fetch presents `instr`/`pc`
- in_ready  output  1  decoder can accept (registered)
- instr  input  32  RV32I instruction word
- pc  input  32  address of `instr`
- flush  input  1  discard all held entries (branch redirect)
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute stage accepts bundle
- out_alu_op  output  4  ALU operation code
- out_a_sel  output  2  operand A: 00 rs1, 01 pc, 10 zero
- out_use_imm  output  1  operand B is `out_imm` instead of rs2
- out_imm  output  32  sign-extended immediate (I/S/B/U/J per opcode)
- out_rs1  output  5  source register 1 index
- out_rs2  output  5  source register 2 index
- out_rd  output  5  destination register index
- out_rd_we  output  1  register write enable
- out_is_branch  output  1  conditional branch
- out_br_invert  output  1  branch taken when ALU bit0 = 0
- out_is_jump  output  1  JAL/JALR
- out_is_load  output  1  load instruction
- out_is_store  output  1  store instruction
- out_funct3  output  3  funct3 passthrough (memory width/sign)
- out_pc  output  32  pc of the decoded instruction
- out_illegal  output  1  unsupported encoding

Behaviour:
- Reset (`rst` = 1 at edge):
  - `out_valid` = 0, `in_ready` = 1, skid empty.
  - `out_alu_op` = 4'b1010 (NONE); all flags 0; imm/reg fields 0; `out_pc` = RESET_PC.
- ALU op codes:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
  - NONE 1010, EQ 1011, GE 1100, GEU 1101.
  - GE and GEU are reserved; the decoder never emits them.
- Decode rules:
  - OP (0110011): op from funct3, plus funct7[5] for SUB/SRA; `out_use_imm` = 0.
  - OP-IMM (0010011): `out_use_imm` = 1, I-immediate.
    - SLLI/SRLI/SRAI take shamt = instr[24:20], zero-extended.
    - funct7 other than 0000000/0100000 (0100000 only for SRAI) -> illegal.
  - LUI: `out_a_sel` = zero, U-immediate, ADD.
  - AUIPC: `out_a_sel` = pc, U-immediate, ADD.
  - JAL: `out_a_sel` = pc, J-immediate, ADD, `out_is_jump` = 1.
  - JALR: `out_a_sel` = rs1, I-immediate, ADD, `out_is_jump` = 1.
  - LOAD: ADD rs1+imm (I-type), `out_is_load` = 1.
  - STORE: ADD rs1+imm (S-type), `out_is_store` = 1, `out_rd_we` = 0.
  - BRANCH (B-immediate, `out_is_branch` = 1):
    - BEQ -> EQ, invert 0; BNE -> EQ, invert 1.
    - BLT -> SLT, invert 0; BGE -> SLT, invert 1.
    - BLTU -> SLTU, invert 0; BGEU -> SLTU, invert 1.
    - funct3 010/011 -> illegal.
- `out_rd_we` = 1 only for OP, OP-IMM, LUI, AUIPC, JAL, JALR and LOAD, and only when rd ≠ 0.
- Illegal instruction (any other opcode or reserved funct field):
  - `out_illegal` = 1, op = NONE, `out_rd_we` = 0, all other flags 0.
  - The bundle is still emitted as valid.
- Handshake:
  - Transfer in when `in_valid` & `in_ready`; transfer out when `out_valid` & `out_ready`.
  - Latency: 1 cycle from input acceptance to `out_valid`, when the output register is empty or draining.
  - Output register free (empty, or `out_ready` = 1 this cycle): accepted bundle loads into it.
  - Output register held (`out_valid` & !`out_ready`): accepted bundle goes to skid; `in_ready` drops next cycle.
  - While skid is full and output drains: skid moves to the output register, `in_ready` rises next cycle.
  - Order is preserved; a bundle is never duplicated or dropped except by flush.
  - Outputs are stable while `out_valid` & !`out_ready`.
- Flush:
  - Next cycle `out_valid` = 0, skid empty, `in_ready` = 1.
  - An input offered in the same cycle as flush is discarded.
  - Flush has priority over every transfer; `rst` has priority over flush.

Decomposition:
- Package `rv32i_pkg`:
  - `alu_op_t` enum with the codes above.
  - opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH).
  - `a_sel_t` enum.
  - `dec_bundle_t` packed struct holding all `out_*` fields except `out_valid`.
- Sub-module `instr_decode_comb`: purely combinational `instr`+`pc` -> `dec_bundle_t`.
- The top holds the output register, skid register and handshake.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2), `out_ready` = 1 -> next cycle: `out_valid` = 1, op 0000, rs1 = 1, rs2 = 2, rd = 3, `out_rd_we` = 1, `out_use_imm` = 0.
- 0xFFF00093 (ADDI x1,x0,-1) -> op 0000, `out_imm` = 0xFFFFFFFF, `out_use_imm` = 1, rd = 1; 0x4032D293 (SRAI x5,x5,3) -> op 0111, `out_imm` = 3.
- 0x00209463 (BNE x1,x2,+8) -> op 1011, `out_is_branch` = 1, `out_br_invert` = 1, `out_imm` = 8, `out_rd_we` = 0.
- Backpressure, inputs A, B, C back-to-back, `out_ready` = 0 for 3 cycles then 1 -> `in_ready` falls after B is accepted; order A, B, C out; no loss.
- With output and skid both full, pulse `flush` -> next cycle `out_valid` = 0, `in_ready` = 1; neither held bundle ever appears.
- 0xFFFFFFFF -> `out_illegal` = 1, op 1010, `out_rd_we` = 0; `rst` mid-stream -> all outputs at reset values next cycle.
